// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: frames 11-bit packets from debounced clock/data lines
// and folds E0/F0 prefixes into single key events.
module ps2_rx #(
  parameter int unsigned TIMEOUT = 100000,
  parameter int unsigned TO_W    = 17
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       rx_err_o,
  output logic [7:0] key_code_o,
  output logic       key_ext_o,
  output logic       key_brk_o,
  output logic       key_valid_o
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e          state_q, state_d;
  logic            clk_prev_q;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_err_q, rx_err_d;
  logic [7:0]      key_code_q, key_code_d;
  logic            key_ext_q, key_ext_d;
  logic            key_brk_q, key_brk_d;
  logic            key_valid_q, key_valid_d;
  logic            ext_pend_q, ext_pend_d;
  logic            brk_pend_q, brk_pend_d;

  logic fall, timeout, frame_ok;

  assign fall     = clk_prev_q & ~ps2_clk_i;
  // A fall restarts the count, so it wins over a coincident expiry.
  assign timeout  = (state_q != IDLE) && !fall && (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign frame_ok = ps2_data_i & (^{shift_q, parity_q});

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    rx_err_d    = 1'b0;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_brk_d   = key_brk_q;
    key_valid_d = 1'b0;
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    to_cnt_d    = (fall || state_q == IDLE) ? '0 : to_cnt_q + TO_W'(1);

    if (timeout) begin
      state_d  = IDLE;
      rx_err_d = 1'b1;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (!ps2_data_i) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d   = {ps2_data_i, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          parity_d = ps2_data_i;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (frame_ok) begin
            rx_byte_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            rx_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Key assembly runs one cycle behind the byte strobe.
    if (rx_valid_q) begin
      case (rx_byte_q)
        8'hE0: ext_pend_d = 1'b1;
        8'hF0: brk_pend_d = 1'b1;
        default: begin
          key_code_d  = rx_byte_q;
          key_ext_d   = ext_pend_q;
          key_brk_d   = brk_pend_q;
          key_valid_d = 1'b1;
          ext_pend_d  = 1'b0;
          brk_pend_d  = 1'b0;
        end
      endcase
    end else if (rx_err_q) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      clk_prev_q  <= 1'b1;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      to_cnt_q    <= '0;
      rx_byte_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_err_q    <= 1'b0;
      key_code_q  <= 8'h00;
      key_ext_q   <= 1'b0;
      key_brk_q   <= 1'b0;
      key_valid_q <= 1'b0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_prev_q  <= ps2_clk_i;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      to_cnt_q    <= to_cnt_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      rx_err_q    <= rx_err_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_brk_q   <= key_brk_d;
      key_valid_q <= key_valid_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
    end
  end

  assign rx_byte_o   = rx_byte_q;
  assign rx_valid_o  = rx_valid_q;
  assign rx_err_o    = rx_err_q;
  assign key_code_o  = key_code_q;
  assign key_ext_o   = key_ext_q;
  assign key_brk_o   = key_brk_q;
  assign key_valid_o = key_valid_q;

endmodule
